serial_comparator: RTL and testbench
====================================

// Module: serial_comparator
// PURPOSE
//  Bit-serial N-bit magnitude comparator (unsigned).
//  Latches two W-bit operands on start, then resolves one bit pair per clock, MSB first,
//  using a 1-bit less/equal/greater decision.
//  Produces registered one-hot l/e/g flags and a one-cycle done pulse.
//  Sits after the 1-bit compare cell and turns it into a word-level compare stage.
// PARAMETERS
//  W  8  operand width in bits; legal range W >= 1
// PORTS
//  clk    in   1  clock; rising-edge active
//  rst_n  in   1  asynchronous, active-low reset
//  start  in   1  request a compare; sampled on rising clk
//  a      in   W  operand A; sampled only when start is accepted
//  b      in   W  operand B; sampled only when start is accepted
//  busy   out  1  high while state is CMP
//  done   out  1  one-cycle pulse; l/e/g are valid and new
//  l      out  1  result A < B
//  e      out  1  result A == B
//  g      out  1  result A > B
// BEHAVIOUR
//  Reset:
//   - One clock domain. rst_n low clears asynchronously; release is synchronous to clk.
//   - Reset values: state=IDLE, busy=0, done=0, l=0, e=0, g=0.
//   - Shift registers and bit counter also clear to 0.
//  States: IDLE, CMP, DONE.
//   - IDLE: busy=0, done=0.
//   - CMP: busy=1, done=0.
//   - DONE: busy=0, done=1 for exactly one cycle.
//  Accept: start=1 at an edge while state is IDLE or DONE.
//   - On accept: load a_sh=a, b_sh=b, cnt=W-1, clear the internal decided flag, go to CMP.
//   - start in CMP is ignored. No queueing. Operands are not re-sampled.
//  CMP, each edge, on bit i=cnt (MSB first, i = W-1 down to 0):
//   - bit decision: lt=~a_sh[i]&b_sh[i], eq=~(a_sh[i]^b_sh[i]), gt=a_sh[i]&~b_sh[i].
//   - First bit with eq=0: record lt/gt and set decided.
//   - Bits after decided do not change the recorded result.
//   - At i=0, or early per CONFIGURATION: load l/e/g and go to DONE.
//   - Otherwise decrement cnt.
//   - e=1 only if every compared bit had eq=1.
//  Output update:
//   - l/e/g update only on the edge that enters DONE.
//   - They hold until the next DONE entry, so they stay stable through IDLE and the next CMP.
//   - After the first completion, exactly one of l/e/g is 1.
//  DONE next state: start=1 -> CMP (back-to-back, no idle gap); else -> IDLE.
//  Latency (start accepted at edge 0):
//   - Done is visible after edge W, without early exit.
//   - Throughput is one compare per W+1 cycles.
//  Boundaries:
//   - W=1: one CMP cycle, done after edge 1.
//   - Operand values all-0 and all-1 are compared correctly.
//   - cnt never wraps; CMP exits at i=0.
//   - rst_n low mid-CMP: abort immediately to reset values. No done is issued for the aborted op.
// CONFIGURATION
//  Macro SERIAL_CMP_EARLY_EXIT_EN:
//   - Defined: CMP goes to DONE on the edge that resolves the first differing bit p.
//     Done is visible after edge W-p. Equal operands still take W edges.
//   - Undefined: always exactly W CMP edges, data-independent (constant-time).
//   - Result values are identical either way. Only timing differs.
// TESTING
//  - Reset: hold rst_n=0, toggle start/a/b -> busy=0, done=0, l=e=g=0 throughout.
//  - W=8, a=8'hA5, b=8'hA5 -> done after edge 8; e=1, l=0, g=0. Same timing with or without the macro.
//  - W=8, a=8'h80, b=8'h7F -> g=1.
//     With SERIAL_CMP_EARLY_EXIT_EN: done after edge 1.
//     Without it: done after edge 8.
//  - W=8, a=8'h12, b=8'h13 -> l=1, done after edge 8 in both builds.
//  - Protocol:
//     Pulse start again at edge 3 with a=8'hFF, b=8'h00 -> ignored; the first result is returned.
//     Then start in the DONE cycle -> busy=1 next cycle, second result g=1.
//  - Reset mid-op: assert rst_n=0 at edge 4 of a compare -> outputs go to reset values asynchronously.
//     No done pulse. A fresh start after release works normally.

Source files
------------

// File: rtl/serial_comparator.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit pair per clock.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN: finish on the first differing bit instead of after W bits.
module serial_comparator #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic         l,
   output logic         e,
   output logic         g
);

   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CMP  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t         state, state_nx;
   logic [W-1:0]   a_sh, a_sh_nx;
   logic [W-1:0]   b_sh, b_sh_nx;
   logic [CW-1:0]  cnt, cnt_nx;
   logic           decided, decided_nx;
   logic           rec_lt, rec_lt_nx;
   logic           rec_gt, rec_gt_nx;
   logic           busy_nx, done_nx;
   logic           l_nx, e_nx, g_nx;
   logic           bit_lt_c, bit_eq_c, bit_gt_c;
   logic           last_c;

   // The operands shift left, so the bit under test is always the MSB of the shifters.
   always_comb begin
      bit_lt_c = ~a_sh[W-1] &  b_sh[W-1];
      bit_gt_c =  a_sh[W-1] & ~b_sh[W-1];
      bit_eq_c = ~(a_sh[W-1] ^ b_sh[W-1]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         a_sh    <= '0;
         b_sh    <= '0;
         cnt     <= '0;
         decided <= 1'b0;
         rec_lt  <= 1'b0;
         rec_gt  <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         l       <= 1'b0;
         e       <= 1'b0;
         g       <= 1'b0;
      end else begin
         state   <= state_nx;
         a_sh    <= a_sh_nx;
         b_sh    <= b_sh_nx;
         cnt     <= cnt_nx;
         decided <= decided_nx;
         rec_lt  <= rec_lt_nx;
         rec_gt  <= rec_gt_nx;
         busy    <= busy_nx;
         done    <= done_nx;
         l       <= l_nx;
         e       <= e_nx;
         g       <= g_nx;
      end
   end

   // Next-state, datapath and registered-output decode.
   always_comb begin
      state_nx   = state;
      a_sh_nx    = a_sh;
      b_sh_nx    = b_sh;
      cnt_nx     = cnt;
      decided_nx = decided;
      rec_lt_nx  = rec_lt;
      rec_gt_nx  = rec_gt;
      l_nx       = l;
      e_nx       = e;
      g_nx       = g;
      last_c     = 1'b0;

      case (state)
         IDLE, DONE: begin
            if (start) begin
               a_sh_nx    = a;
               b_sh_nx    = b;
               cnt_nx     = CW'(W - 1);
               decided_nx = 1'b0;
               rec_lt_nx  = 1'b0;
               rec_gt_nx  = 1'b0;
               state_nx   = CMP;
            end else begin
               state_nx   = IDLE;
            end
         end
         CMP: begin
            a_sh_nx = a_sh << 1;
            b_sh_nx = b_sh << 1;
            if (!decided && !bit_eq_c) begin
               decided_nx = 1'b1;
               rec_lt_nx  = bit_lt_c;
               rec_gt_nx  = bit_gt_c;
            end
`ifdef SERIAL_CMP_EARLY_EXIT_EN
            last_c = (cnt == '0) || (!decided && !bit_eq_c);
`else
            last_c = (cnt == '0);
`endif
            if (last_c) begin
               // A bit deciding on this very edge has not reached rec_* yet.
               l_nx     = decided ? rec_lt : bit_lt_c;
               g_nx     = decided ? rec_gt : bit_gt_c;
               e_nx     = ~decided & bit_eq_c;
               state_nx = DONE;
            end else begin
               cnt_nx   = cnt - CW'(1);
            end
         end
         default: state_nx = IDLE;
      endcase

      busy_nx = (state_nx == CMP);
      done_nx = (state_nx == DONE);
   end

endmodule

// File: tb/tb_serial_comparator.sv
// Directed self-checking bench for serial_comparator (W=8), either build of SERIAL_CMP_EARLY_EXIT_EN.
module tb_serial_comparator;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       busy, done, l, e, g;

   int n_total = 0;
   int n_pass  = 0;
   int lat;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
   localparam int EARLY = 1;
`else
   localparam int EARLY = 0;
`endif

   serial_comparator #(.W(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .a     (a),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .l     (l),
      .e     (e),
      .g     (g)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Drive start for exactly one edge (edge 0 of the op), return #1 after it.
   task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
      @(negedge clk);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // Count edges until done is seen; -1 if it never comes.
   task automatic wait_done(output int edges);
      edges = -1;
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk);
         #1;
         if (done) begin
            edges = k;
            break;
         end
      end
   endtask

   task automatic run_cmp(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input int exp_lat, input logic [2:0] exp_leg);
      int t;
      start_op(av, bv);
      wait_done(t);
      check({tag, "_lat"}, 32'(t), 32'(exp_lat));
      check({tag, "_leg"}, 32'({l, e, g}), 32'(exp_leg));
      check({tag, "_busy"}, 32'(busy), 32'd0);
   endtask

   initial begin
      // Reset held: outputs stay at zero regardless of inputs.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         start = ~start;
         a     = 8'(8'h31 * (i + 1));
         b     = 8'(8'h17 * (i + 2));
         @(posedge clk);
         #1 check("reset_hold", 32'({busy, done, l, e, g}), 32'd0);
      end
      @(negedge clk);
      start = 1'b0;
      rst_n = 1'b1;

      run_cmp("eq_a5", 8'hA5, 8'hA5, 8, 3'b010);
      @(posedge clk);
      #1 check("done_pulse_width", 32'({busy, done}), 32'd0);
      check("hold_in_idle", 32'({l, e, g}), 32'(3'b010));

      run_cmp("gt_80_7f", 8'h80, 8'h7F, EARLY ? 1 : 8, 3'b001);
      run_cmp("lt_12_13", 8'h12, 8'h13, 8, 3'b100);
      run_cmp("eq_00",    8'h00, 8'h00, 8, 3'b010);
      run_cmp("eq_ff",    8'hFF, 8'hFF, 8, 3'b010);
      run_cmp("lt_00_ff", 8'h00, 8'hFF, EARLY ? 1 : 8, 3'b100);
      run_cmp("gt_ff_00", 8'hFF, 8'h00, EARLY ? 1 : 8, 3'b001);
      run_cmp("gt_0b_0a", 8'h0B, 8'h0A, 8, 3'b001);

      // Start during CMP is ignored; operands are not re-sampled.
      start_op(8'h12, 8'h13);
      repeat (2) @(posedge clk);
      #1;
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'h00;
      @(posedge clk);
      #1 start = 1'b0;
      check("ignored_busy", 32'(busy), 32'd1);
      check("stable_in_cmp", 32'({l, e, g}), 32'(3'b001));
      wait_done(lat);
      check("ignored_lat", 32'(lat), 32'd5);
      check("ignored_leg", 32'({l, e, g}), 32'(3'b100));

      // Back-to-back start in the DONE cycle.
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'h00;
      @(posedge clk);
      #1 start = 1'b0;
      check("b2b_busy_done", 32'({busy, done}), 32'(2'b10));
      check("b2b_hold_leg", 32'({l, e, g}), 32'(3'b100));
      wait_done(lat);
      check("b2b_lat", 32'(lat), EARLY ? 32'd1 : 32'd8);
      check("b2b_leg", 32'({l, e, g}), 32'(3'b001));

      // Reset in the middle of a compare aborts with no done.
      start_op(8'h12, 8'h13);
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("midreset_async", 32'({busy, done, l, e, g}), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1 check("midreset_hold", 32'({busy, done, l, e, g}), 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      run_cmp("post_reset_gt", 8'hA5, 8'h5A, EARLY ? 1 : 8, 3'b001);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
